pipeline_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the in-order MIPS pipeline (IF, ID, EX, DM, WB). It tracks the destination register of every in-flight instruction after ID in a shift-register scoreboard. From that state it drives the forwarding-mux selects for EX, a load-use stall for IF/ID, and flushes on a taken branch. Stage count and load latency are generic, so deeper pipelines reuse the block unchanged. It sits beside the ID stage and feeds the IF_ID, ID_EX and EX input muxes.

---
 rtl/pipeline_hazard_unit_pkg.sv | 24 ++
 rtl/hazard_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_unit.sv | 109 ++++++++++
 tb/tb_pipeline_hazard_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Scoreboard entries carry a fixed-width rd so the struct can live here; narrower register files zero-extend.
package pipeline_hazard_unit_pkg;

    localparam int RD_W_MAX = 8;
    localparam int FWD_RF   = 0;
    localparam logic [RD_W_MAX-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        logic [RD_W_MAX-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: '0, reg_write: 1'b0, mem_read: 1'b0};

    // A source hits an entry only if that entry really writes it and the reader really reads it.
    function automatic logic src_match(input sb_entry_t e, input logic [RD_W_MAX-1:0] src,
                                       input logic uses);
        return e.valid && e.reg_write && (e.rd == src) && (src != REG_ZERO) && uses;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter used for the hazard unit performance statistics.
module hazard_sat_counter #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {PERF_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller: shift-register scoreboard of post-ID instructions,
// EX forwarding selects, load-use stall and taken-branch flush.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int PERF_W     = 16,
    parameter int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    output logic                  stall_id,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [FWD_SEL_W-1:0]  fwd_sel_rs,
    output logic [FWD_SEL_W-1:0]  fwd_sel_rt,
    output logic [PERF_W-1:0]     stall_count,
    output logic [PERF_W-1:0]     flush_count,
    output logic [PERF_W-1:0]     issue_count
);

    sb_entry_t sb_q [FWD_STAGES];
    sb_entry_t sb_d [FWD_STAGES];

    logic [RD_W_MAX-1:0]   rs_x, rt_x, rd_x;
    logic [FWD_STAGES-1:0] hit_rs, hit_rt;
    logic [FWD_SEL_W-1:0]  sel_rs, sel_rt;
    logic                  lu_rs, lu_rt;
    logic                  load_use, bubble, issue;

    assign rs_x = RD_W_MAX'(id_rs);
    assign rt_x = RD_W_MAX'(id_rt);
    assign rd_x = RD_W_MAX'(id_rd);

    for (genvar i = 0; i < FWD_STAGES; i++) begin : g_match
        assign hit_rs[i] = src_match(sb_q[i], rs_x, id_uses_rs);
        assign hit_rt[i] = src_match(sb_q[i], rt_x, id_uses_rt);
    end

    // Walk oldest to youngest so the youngest hit overwrites; it alone decides forwarding and load-use.
    always_comb begin
        sel_rs = FWD_SEL_W'(FWD_RF);
        sel_rt = FWD_SEL_W'(FWD_RF);
        lu_rs  = 1'b0;
        lu_rt  = 1'b0;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (hit_rs[i]) begin
                sel_rs = FWD_SEL_W'(i + 1);
                lu_rs  = sb_q[i].mem_read && (i < LOAD_LAT);
            end
            if (hit_rt[i]) begin
                sel_rt = FWD_SEL_W'(i + 1);
                lu_rt  = sb_q[i].mem_read && (i < LOAD_LAT);
            end
        end
    end

    // A taken branch makes the stalled consumer wrong-path, so the flush overrides the stall.
    assign load_use    = lu_rs || lu_rt;
    assign stall_id    = reset && load_use && !branch_taken;
    assign flush_if_id = reset && branch_taken;
    assign flush_id_ex = reset && branch_taken;
    assign fwd_sel_rs  = reset ? sel_rs : FWD_SEL_W'(FWD_RF);
    assign fwd_sel_rt  = reset ? sel_rt : FWD_SEL_W'(FWD_RF);

    assign bubble = stall_id || flush_id_ex || !id_valid;
    assign issue  = !bubble;

    always_comb begin
        sb_d[0] = SB_BUBBLE;
        if (!bubble) begin
            sb_d[0].valid     = 1'b1;
            sb_d[0].rd        = rd_x;
            sb_d[0].reg_write = id_reg_write;
            sb_d[0].mem_read  = id_mem_read;
        end
        for (int i = 1; i < FWD_STAGES; i++)
            sb_d[i] = sb_q[i-1];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FWD_STAGES; i++) begin
            if (!reset) sb_q[i] <= SB_BUBBLE;
            else        sb_q[i] <= sb_d[i];
        end
    end

    hazard_sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_id), .count(stall_count)
    );
    hazard_sat_counter #(.PERF_W(PERF_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(flush_id_ex), .count(flush_count)
    );
    hazard_sat_counter #(.PERF_W(PERF_W)) u_issue_cnt (
        .clk(clk), .reset(reset), .inc(issue), .count(issue_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: expectations are queued as stimulus is driven
// and popped against the DUT outputs on the falling edge.
module tb_pipeline_hazard_unit;

    localparam int RAW = 5;
    localparam int FS  = 3;
    localparam int PW  = 8;
    localparam int SW  = $clog2(FS + 1);
    localparam int SAT = (1 << PW) - 1;

    localparam int K_STALL = 0, K_FLUSH = 1, K_SRS = 2, K_SRT = 3,
                   K_SCNT = 4, K_FCNT = 5, K_ICNT = 6;

    typedef struct {
        int    kind;
        int    val;
        string tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, branch_taken;
    logic [RAW-1:0] id_rs, id_rt, id_rd;
    logic           stall_id, flush_if_id, flush_id_ex;
    logic [SW-1:0]  fwd_sel_rs, fwd_sel_rt;
    logic [PW-1:0]  stall_count, flush_count, issue_count;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_stall = 0, m_flush = 0, m_issue = 0;
    logic e_stall, e_flush;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.REG_ADDR_W(RAW), .FWD_STAGES(FS), .LOAD_LAT(1), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .stall_id(stall_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .stall_count(stall_count),
        .flush_count(flush_count), .issue_count(issue_count)
    );

    function automatic int observe(input int kind);
        case (kind)
            K_STALL: return (stall_id === 1'b1 && flush_if_id === flush_id_ex) ? 1 : int'(stall_id);
            K_FLUSH: return (flush_if_id === flush_id_ex) ? int'(flush_id_ex) : 2;
            K_SRS:   return int'(fwd_sel_rs);
            K_SRT:   return int'(fwd_sel_rt);
            K_SCNT:  return int'(stall_count);
            K_FCNT:  return int'(flush_count);
            default: return int'(issue_count);
        endcase
    endfunction

    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input int rd, input logic rw, input logic mr,
                         input logic br);
        id_valid     = v;
        id_rs        = RAW'(rs);
        id_rt        = RAW'(rt);
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_rd        = RAW'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        branch_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_haz(input string tag, input logic st, input logic fl,
                              input int srs, input int srt);
        q.push_back('{K_STALL, int'(st), {tag, ".stall"}});
        q.push_back('{K_FLUSH, int'(fl), {tag, ".flush"}});
        q.push_back('{K_SRS, srs, {tag, ".sel_rs"}});
        q.push_back('{K_SRT, srt, {tag, ".sel_rt"}});
        e_stall = st;
        e_flush = fl;
    endtask

    task automatic expect_cnt(input string tag);
        q.push_back('{K_SCNT, m_stall, {tag, ".stall_count"}});
        q.push_back('{K_FCNT, m_flush, {tag, ".flush_count"}});
        q.push_back('{K_ICNT, m_issue, {tag, ".issue_count"}});
    endtask

    // Check queued expectations at the falling edge, then cross the rising edge and advance the counter model.
    task automatic tick();
        exp_t e;
        int   o;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            o = observe(e.kind);
            total++;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s got=%0d exp=%0d", e.tag, o, e.val);
            end
        end
        if (!reset) begin
            m_stall = 0; m_flush = 0; m_issue = 0;
        end else begin
            if (e_stall && m_stall < SAT) m_stall++;
            if (e_flush && m_flush < SAT) m_flush++;
            if (id_valid && !e_stall && !e_flush && m_issue < SAT) m_issue++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < FS; i++) begin
            idle();
            expect_haz(tag, 1'b0, 1'b0, 0, 0);
            tick();
        end
    endtask

    initial begin
        int stalls;
        int k;
        reset = 1'b0;
        idle();
        e_stall = 1'b0;
        e_flush = 1'b0;
        @(posedge clk);
        #1;
        // reset state: hazard outputs forced low even with a branch pending
        drive(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1);
        expect_haz("rst", 1'b0, 1'b0, 0, 0);
        expect_cnt("rst");
        tick();
        reset = 1'b1;

        // add r3,r1,r2 ; sub r4,r3,r5
        drive(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        expect_haz("add", 1'b0, 1'b0, 0, 0);
        tick();
        drive(1'b1, 3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        expect_haz("sub_fwd", 1'b0, 1'b0, 1, 0);
        tick();
        idle();
        expect_haz("alu_idle", 1'b0, 1'b0, 0, 0);
        expect_cnt("alu");
        tick();
        drain("alu_drain");

        // lw r3,0(r1) ; add r4,r3,r3 -> one stall then forward from entry 1
        drive(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        expect_haz("lw", 1'b0, 1'b0, 0, 0);
        tick();
        drive(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        expect_haz("lu_stall", 1'b1, 1'b0, 1, 1);
        tick();
        expect_haz("lu_go", 1'b0, 1'b0, 2, 2);
        tick();
        idle();
        expect_haz("lu_idle", 1'b0, 1'b0, 0, 0);
        expect_cnt("lu");
        tick();
        drain("lu_drain");

        // writer r7, two gaps, reader r7 -> WB entry
        drive(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0);
        expect_haz("w7", 1'b0, 1'b0, 0, 0);
        tick();
        for (k = 0; k < 2; k++) begin
            drive(1'b1, 1, 2, 1'b1, 1'b1, 8 + k, 1'b1, 1'b0, 1'b0);
            expect_haz("gap", 1'b0, 1'b0, 0, 0);
            tick();
        end
        drive(1'b1, 7, 7, 1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0);
        expect_haz("wb_fwd", 1'b0, 1'b0, 3, 3);
        tick();
        drain("wb_drain");

        // writer r7, three gaps, reader r7 -> register file
        drive(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0);
        expect_haz("w7b", 1'b0, 1'b0, 0, 0);
        tick();
        for (k = 0; k < 3; k++) begin
            drive(1'b1, 1, 2, 1'b1, 1'b1, 8 + k, 1'b1, 1'b0, 1'b0);
            expect_haz("gapb", 1'b0, 1'b0, 0, 0);
            tick();
        end
        drive(1'b1, 7, 7, 1'b1, 1'b1, 11, 1'b1, 1'b0, 1'b0);
        expect_haz("rf_read", 1'b0, 1'b0, 0, 0);
        tick();
        drain("rf_drain");

        // load-use coincident with a taken branch: flush wins, entry 0 bubbles
        drive(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        expect_haz("lw_br", 1'b0, 1'b0, 0, 0);
        tick();
        drive(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1);
        expect_haz("br_vs_lu", 1'b0, 1'b1, 1, 1);
        tick();
        drive(1'b1, 4, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
        expect_haz("br_bubble", 1'b0, 1'b0, 0, 2);
        expect_cnt("br");
        tick();
        drain("br_drain");

        // r0 writers (ALU and load) never forward or stall
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        expect_haz("w0", 1'b0, 1'b0, 0, 0);
        tick();
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        expect_haz("r0_vs_w0", 1'b0, 1'b0, 0, 0);
        tick();
        drive(1'b1, 0, 0, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        expect_haz("r0_vs_lw0", 1'b0, 1'b0, 0, 0);
        tick();
        drain("r0_drain");

        // reset during a load-use stall
        drive(1'b1, 1, 0, 1'b1, 1'b0, 5, 1'b1, 1'b1, 1'b0);
        expect_haz("lw5", 1'b0, 1'b0, 0, 0);
        tick();
        drive(1'b1, 5, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
        expect_haz("lu5", 1'b1, 1'b0, 1, 1);
        tick();
        reset = 1'b0;
        branch_taken = 1'b1;
        expect_haz("rst_mid", 1'b0, 1'b0, 0, 0);
        tick();
        reset = 1'b1;
        branch_taken = 1'b0;
        expect_haz("post_rst", 1'b0, 1'b0, 0, 0);
        expect_cnt("post_rst");
        tick();
        drain("rst_drain");

        // lw r3,0(r3) repeated: stalls every other cycle until stall_count saturates
        stalls = 0;
        k = 0;
        while (stalls < SAT + 6) begin
            drive(1'b1, 3, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0);
            if (k == 0)          expect_haz("sat0", 1'b0, 1'b0, 0, 0);
            else if (k % 2 == 1) expect_haz("sat_st", 1'b1, 1'b0, 1, 0);
            else                 expect_haz("sat_go", 1'b0, 1'b0, 2, 0);
            if (k % 2 == 1) stalls++;
            tick();
            k++;
        end
        idle();
        expect_haz("sat_end", 1'b0, 1'b0, 0, 0);
        expect_cnt("sat");
        tick();
        total++;
        assert (stall_count === PW'(SAT)) else begin
            bad++;
            $error("FAIL sat_hold got=%0d exp=%0d", stall_count, SAT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
